// File: rtl/sigdel_cic_decimator.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream.
// Produces one signal_bitwidth-bit PCM sample every 2^decimation_log2 enabled clocks.
module sigdel_cic_decimator #(
  parameter int signal_bitwidth = 24,
  parameter int decimation_log2 = 6
) (
  input  logic                              clock_200,
  input  logic                              reset_n,
  input  logic                              input_bitstream,
  input  logic                              input_enable,
  output logic signed [signal_bitwidth-1:0] output_data,
  output logic                              output_valid
);
  localparam int W  = 3 * decimation_log2 + 2;
  localparam int S  = signal_bitwidth - 1 - 3 * decimation_log2;
  localparam int YW = W + S;

  localparam logic [YW-1:0] POS_FS = {2'b01, {(signal_bitwidth-1){1'b0}}};
  localparam logic [signal_bitwidth-1:0] POS_MAX = {1'b0, {(signal_bitwidth-1){1'b1}}};

  logic [W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [W-1:0] x, c1, c2, c3;
  logic [decimation_log2-1:0] cnt_q, cnt_d;
  logic [1:0] warm_q, warm_d;
  logic [signal_bitwidth-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic strobe;
  logic [YW-1:0] y;
  logic [signal_bitwidth-1:0] y_sat;

  assign x      = input_bitstream ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
  assign strobe = input_enable && (&cnt_q);

  assign c1 = i3_q - d1_q;
  assign c2 = c1 - d2_q;
  assign c3 = c2 - d3_q;

  // Upper S bits of the zero-extension are shifted out, so y[YW-1:S] is exactly c3.
  assign y     = YW'(c3) << S;
  assign y_sat = (y == POS_FS) ? POS_MAX : y[signal_bitwidth-1:0];

  always_comb begin
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (input_enable) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + decimation_log2'(1);
      if (strobe) begin
        d1_d   = i3_q;
        d2_d   = c1;
        d3_d   = c2;
        data_d = y_sat;
        // Combs need three frames to flush, so the first three samples are not flagged.
        if (warm_q == 2'd3) valid_d = 1'b1;
        else                warm_d  = warm_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      cnt_q   <= '0;
      warm_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign output_data  = $signed(data_q);
  assign output_valid = valid_q;
endmodule

// File: tb/tb_sigdel_cic_decimator.sv
// Bench for sigdel_cic_decimator: two instances (R=64, R=32) driven by one stream,
// checked every cycle against a closed-form CIC model built from the input history.
module tb_sigdel_cic_decimator;
  localparam int SW = 24;
  localparam int L0 = 6;
  localparam int L1 = 5;
  localparam longint FS = longint'(1) << (SW - 1);

  logic clock_200 = 1'b0;
  logic reset_n   = 1'b0;
  logic bit_in    = 1'b0;
  logic en        = 1'b0;
  logic signed [SW-1:0] data0, data1;
  logic valid0, valid1;

  int total = 0;
  int bad   = 0;

  always #5 clock_200 = ~clock_200;

  sigdel_cic_decimator #(.signal_bitwidth(SW), .decimation_log2(L0)) u_dut0 (
    .clock_200(clock_200), .reset_n(reset_n), .input_bitstream(bit_in),
    .input_enable(en), .output_data(data0), .output_valid(valid0));

  sigdel_cic_decimator #(.signal_bitwidth(SW), .decimation_log2(L1)) u_dut1 (
    .clock_200(clock_200), .reset_n(reset_n), .input_bitstream(bit_in),
    .input_enable(en), .output_data(data1), .output_valid(valid1));

  // Reference model: i3 after n samples is sum x_j * C(n-1-j, 2); the comb is a
  // third difference of i3 across successive strobes; then wrap, scale, saturate.
  int     hist[$];
  longint p1[2], p2[2], p3[2];
  int     nstr[2];
  logic signed [SW-1:0] exp_data[2];
  logic   exp_valid[2];
  int     m_r;
  longint m_v, m_c;

  function automatic longint i3_at(input int n);
    longint acc;
    longint k;
    acc = 0;
    for (int j = 0; j < n; j++) begin
      k = longint'(n - 1 - j);
      acc += longint'(hist[j]) * ((k * (k - 1)) / 2);
    end
    return acc;
  endfunction

  function automatic logic signed [SW-1:0] rescale(input longint c, input int l);
    longint m, cw, y;
    int w, s;
    w  = 3 * l + 2;
    s  = SW - 1 - 3 * l;
    m  = longint'(1) << w;
    cw = c % m;
    if (cw < 0) cw += m;
    if (cw >= m / 2) cw -= m;
    y = cw * (longint'(1) << s);
    if (y == FS) y = FS - 1;
    return y[SW-1:0];
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      p1[k] = 0; p2[k] = 0; p3[k] = 0; nstr[k] = 0;
      exp_data[k] = '0; exp_valid[k] = 1'b0;
    end
  end

  always @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin
        p1[k] = 0; p2[k] = 0; p3[k] = 0; nstr[k] = 0;
        exp_data[k] = '0; exp_valid[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) exp_valid[k] = 1'b0;
      if (en) begin
        for (int k = 0; k < 2; k++) begin
          m_r = 1 << ((k == 0) ? L0 : L1);
          if ((hist.size() + 1) % m_r == 0) begin
            m_v = i3_at(hist.size());
            m_c = m_v - 3 * p1[k] + 3 * p2[k] - p3[k];
            p3[k] = p2[k]; p2[k] = p1[k]; p1[k] = m_v;
            nstr[k]++;
            exp_data[k]  = rescale(m_c, (k == 0) ? L0 : L1);
            exp_valid[k] = (nstr[k] >= 4);
          end
        end
        hist.push_back(bit_in ? 1 : -1);
      end
    end
  end

  task automatic cmp(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clock_200) begin
    cmp("model_valid0", valid0, exp_valid[0]);
    cmp("model_data0",  data0,  exp_data[0]);
    cmp("model_valid1", valid1, exp_valid[1]);
    cmp("model_data1",  data1,  exp_data[1]);
  end

  // Stimulus generators
  bit     ph  = 1'b1;
  bit     tog = 1'b1;
  longint sd_acc = 0;
  longint sd_u   = 0;
  longint sd_s;

  task automatic drive(input int mode);
    case (mode)
      0: begin en = 1'b1; bit_in = 1'b1; end
      1: begin en = 1'b1; bit_in = 1'b0; end
      2: begin en = 1'b1; bit_in = ph; ph = ~ph; end
      3: begin en = tog; bit_in = 1'b1; tog = ~tog; end
      4: begin en = ($urandom_range(0, 3) != 0); bit_in = 1'($urandom_range(0, 1)); end
      default: begin
        en     = 1'b1;
        sd_s   = sd_acc + sd_u;
        bit_in = (sd_s >= 0);
        sd_acc = sd_s - (bit_in ? FS : -FS);
      end
    endcase
  endtask

  task automatic do_reset();
    @(posedge clock_200);
    #2;
    reset_n = 1'b0;
    en      = 1'b0;
    bit_in  = 1'b0;
    #1;
    cmp("rst_data0",  data0,  0);
    cmp("rst_valid0", valid0, 0);
    cmp("rst_data1",  data1,  0);
    cmp("rst_valid1", valid1, 0);
    @(posedge clock_200);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run(input int mode, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      drive(mode);
      @(posedge clock_200);
      #1;
    end
  endtask

  // Reset, run a pattern, check every valid sample against a hand value and the
  // cycle (counted from reset release) on which the first valid pulse appears.
  task automatic phase_lit(input int mode, input longint u, input int ncyc, input longint lit,
                           input longint tol, input int f0, input int f1);
    int c0, c1, nv;
    longint d;
    c0 = -1; c1 = -1; nv = 0;
    ph = 1'b1; tog = 1'b1; sd_acc = 0; sd_u = u;
    do_reset();
    for (int c = 1; c <= ncyc; c++) begin
      drive(mode);
      @(posedge clock_200);
      #1;
      if (valid0) begin
        nv++;
        if (c0 < 0) c0 = c;
        d = longint'(data0) - lit;
        if (d < 0) d = -d;
        total++;
        if (d > tol) begin
          bad++;
          $display("FAIL lit_data0 actual=%0d required=%0d tol=%0d", data0, lit, tol);
        end
      end
      if (valid1) begin
        if (c1 < 0) c1 = c;
        d = longint'(data1) - lit;
        if (d < 0) d = -d;
        total++;
        if (d > tol) begin
          bad++;
          $display("FAIL lit_data1 actual=%0d required=%0d tol=%0d", data1, lit, tol);
        end
      end
    end
    cmp("first_valid0", c0, f0);
    cmp("first_valid1", c1, f1);
    cmp("valid_seen", (nv > 0), 1);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clock_200);
    #1;
    reset_n = 1'b1;

    phase_lit(0, 0, 600, 8388607, 0, 256, 128);
    phase_lit(1, 0, 600, -8388608, 0, 256, 128);
    phase_lit(2, 0, 640, 0, 0, 256, 128);
    phase_lit(3, 0, 1200, 8388607, 0, 511, 255);
    phase_lit(5, 4194304, 600, 4194304, 128, 256, 128);
    phase_lit(5, -4194304, 600, -4194304, 128, 256, 128);
    phase_lit(5, 0, 600, 0, 128, 256, 128);

    // Reset halfway through the fifth frame, then warm-up must restart from scratch.
    do_reset();
    run(0, 287);
    phase_lit(0, 0, 600, 8388607, 0, 256, 128);

    do_reset();
    run(4, 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
